// File: rtl/and_ary_seq_if.sv
// Operand/result handshake bundle for and_ary_seq.
// master = producer/consumer side, slave = controller side.
interface and_ary_seq_if #(
  parameter int N = 16,
  parameter int W = 4
);
  localparam int BW = $clog2(N / W) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic          d0;
  logic [BW-1:0] beats;
  logic          busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, d0, beats, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, d0, beats, busy
  );
endinterface

// File: rtl/and_ary_seq.sv
// Sequential AND-of-pairs reducer: one W-pair slice per cycle,
// accumulated over N/W beats with optional early exit on zero.
module and_ary_seq #(
  parameter int N          = 16,
  parameter int W          = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic       clk,
  input logic       rst,
  and_ary_seq_if.slave io
);
  localparam int NB = N / W;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int BW = $clog2(NB) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic          acc;
  logic [IW-1:0] idx;
  logic [BW-1:0] beats_r;
  logic          d0_r;
  logic          ov_r;

  logic slice;
  logic acc_nx;
  logic last;
  logic stop;
  logic take;
  logic give;

  // pick the W-pair slice addressed by idx and AND-reduce it
  always_comb begin
    slice = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (idx == IW'(k)) begin
        slice = &(a_r[k*W +: W] & b_r[k*W +: W]);
      end
    end
  end

  assign acc_nx = acc & slice;
  assign last   = (idx == IW'(NB - 1));
  assign stop   = last | (EARLY_EXIT & ~acc_nx);
  assign take   = io.in_valid & (state == IDLE);
  assign give   = ov_r & io.out_ready;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state selection
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (take) state_nx = RUN;
      RUN:     if (stop) state_nx = DONE;
      DONE:    if (give) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // operand capture, slice accumulation and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      acc     <= 1'b1;
      idx     <= '0;
      beats_r <= '0;
      d0_r    <= 1'b0;
      ov_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            a_r     <= io.a;
            b_r     <= io.b;
            acc     <= 1'b1;
            idx     <= '0;
            beats_r <= '0;
          end
        end
        RUN: begin
          acc     <= acc_nx;
          beats_r <= beats_r + 1'b1;
          idx     <= idx + 1'b1;
          if (stop) begin
            d0_r <= acc_nx;
            ov_r <= 1'b1;
          end
        end
        DONE: begin
          if (give) ov_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign io.in_ready  = (state == IDLE);
  assign io.busy      = (state != IDLE);
  assign io.out_valid = ov_r;
  assign io.d0        = d0_r;
  assign io.beats     = beats_r;
endmodule

// File: tb/tb_and_ary_seq.sv
// Bench for and_ary_seq: early-exit and full-scan instances
// share stimulus; results are scoreboarded against a model.
module tb_and_ary_seq;
  logic clk = 1'b0;
  logic rst;

  and_ary_seq_if #(.N(16), .W(4)) m ();
  and_ary_seq_if #(.N(16), .W(4)) m0 ();

  and_ary_seq #(.N(16), .W(4), .EARLY_EXIT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .io  (m)
  );

  and_ary_seq #(.N(16), .W(4), .EARLY_EXIT(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .io  (m0)
  );

  assign m0.in_valid  = m.in_valid;
  assign m0.a         = m.a;
  assign m0.b         = m.b;
  assign m0.out_ready = m.out_ready;

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] q1[$];
  logic [3:0] q0[$];
  logic [3:0] e1;
  logic [3:0] e0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // returns {d0, beats}
  function automatic logic [3:0] model(input logic [15:0] av,
                                       input logic [15:0] bv,
                                       input bit ee);
    logic acc;
    int   bt;
    acc = 1'b1;
    bt  = 0;
    for (int k = 0; k < 4; k++) begin
      bt++;
      acc = acc & (&(av[k*4 +: 4] & bv[k*4 +: 4]));
      if (ee && !acc) break;
    end
    return {acc, 3'(bt)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (m.out_valid && m.out_ready) begin
        if (q1.size() == 0) begin
          chk("sb1_empty", 32'd0, 32'd1);
        end else begin
          e1 = q1.pop_front();
          chk("d0_ee1", m.d0, e1[3]);
          chk("beats_ee1", m.beats, e1[2:0]);
        end
      end
      if (m0.in_valid && m0.in_ready)
        q0.push_back(model(m0.a, m0.b, 1'b0));
      if (m0.out_valid && m0.out_ready) begin
        if (q0.size() == 0) begin
          chk("sb0_empty", 32'd0, 32'd1);
        end else begin
          e0 = q0.pop_front();
          chk("d0_ee0", m0.d0, e0[3]);
          chk("beats_ee0", m0.beats, e0[2:0]);
        end
      end
    end
  end

  task automatic send(input logic [15:0] av, input logic [15:0] bv);
    int n;
    m.a        = av;
    m.b        = bv;
    m.in_valid = 1'b1;
    n = 0;
    while (!m.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("accept_to", n < 20, 1);
    q1.push_back(model(av, bv, 1'b1));
    tick();
    m.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int lat, input string tag);
    int n;
    n = 0;
    while (!m.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, n, lat);
  endtask

  task automatic idle0();
    int n;
    n = 0;
    while (!(m0.in_ready && m.in_ready) && n < 20) begin
      tick();
      n++;
    end
    chk("idle_to", n < 20, 1);
  endtask

  task automatic run_one(input logic [15:0] av, input logic [15:0] bv,
                         input int lat);
    send(av, bv);
    chk("rdy_low", m.in_ready, 0);
    chk("busy_run", m.busy, 1);
    wait_out(lat, "latency");
    tick();
    chk("ov_clr", m.out_valid, 0);
    chk("rdy_back", m.in_ready, 1);
    idle0();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst         = 1'b1;
    m.in_valid  = 1'b1;
    m.a         = 16'hFFFF;
    m.b         = 16'hFFFF;
    m.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_rdy", m.in_ready, 1);
    chk("rst_busy", m.busy, 0);
    chk("rst_ov", m.out_valid, 0);
    chk("rst_d0", m.d0, 0);
    chk("rst_beats", m.beats, 0);
    m.in_valid = 1'b0;
    rst        = 1'b0;
    tick();
    chk("idle_busy", m.busy, 0);

    m.out_ready = 1'b1;
    run_one(16'hFFFF, 16'hFFFF, 4);

    send(16'hFFFF, 16'hFF7F);
    wait_out(2, "lat_early");
    chk("ee0_ov_e2", m0.out_valid, 0);
    tick();
    tick();
    chk("ee0_ov_e4", m0.out_valid, 1);
    idle0();

    run_one(16'h7FFF, 16'hFFFF, 4);

    m.out_ready = 1'b0;
    send(16'hFFFF, 16'hFFFF);
    wait_out(4, "lat_bp");
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        m.in_valid = 1'b1;
        m.a        = 16'h0000;
        m.b        = 16'h0000;
      end else begin
        m.in_valid = 1'b0;
      end
      tick();
      chk("bp_ov", m.out_valid, 1);
      chk("bp_d0", m.d0, 1);
      chk("bp_beats", m.beats, 4);
      chk("bp_rdy", m.in_ready, 0);
    end
    m.in_valid  = 1'b0;
    m.out_ready = 1'b1;
    tick();
    chk("bp_ov_clr", m.out_valid, 0);
    chk("bp_rdy_back", m.in_ready, 1);
    idle0();

    m.a        = 16'hFFFF;
    m.b        = 16'hFFFF;
    m.in_valid = 1'b1;
    q1.push_back(model(16'hFFFF, 16'hFFFF, 1'b1));
    tick();
    m.b = 16'h0000;
    q1.push_back(model(16'hFFFF, 16'h0000, 1'b1));
    n = 0;
    while (!m.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("b2b_gap", n, 5);
    tick();
    m.in_valid = 1'b0;
    wait_out(1, "lat_b2b");
    tick();
    chk("b2b_rdy", m.in_ready, 1);
    idle0();

    send(16'hFFFF, 16'hFFFF);
    tick();
    rst = 1'b1;
    q1.delete();
    q0.delete();
    tick();
    rst = 1'b0;
    chk("abort_ov", m.out_valid, 0);
    chk("abort_d0", m.d0, 0);
    chk("abort_beats", m.beats, 0);
    chk("abort_rdy", m.in_ready, 1);
    chk("abort_busy", m.busy, 0);
    send(16'hFFFF, 16'hFFFF);
    wait_out(4, "lat_after_rst");
    tick();
    idle0();
    tick();

    chk("q1_drained", q1.size(), 0);
    chk("q0_drained", q0.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
